// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI byte master
//   SPI_MODE decode bit positions, FSM state encodings, transfer sizing.
package spi_pkg;
    localparam int CPOL_BIT       = 1;
    localparam int CPHA_BIT       = 0;
    localparam int BITS_PER_XFER  = 8;
    localparam int EDGES_PER_XFER = 2 * BITS_PER_XFER;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-bit timer producing leading/trailing spisclk edge strobes
//   clk, rst        : clock, synchronous active-high reset
//   en_i            : count while high, held cleared while low
//   lead_pulse_o    : strobe, next edge is a leading (odd) edge
//   trail_pulse_o   : strobe, next edge is a trailing (even) edge
//   last_edge_o     : strobe, this edge is the final edge of the byte
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic lead_pulse_o,
    output logic trail_pulse_o,
    output logic last_edge_o
);
    localparam int CW = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_HALF_BIT - 1);

    if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half
        $error("CLKS_PER_HALF_BIT must be >= 2");
    end

    logic [CW-1:0] half_cnt_q, half_cnt_d;
    logic [4:0] edge_cnt_q, edge_cnt_d;
    logic wrap;

    always_comb begin
        wrap          = en_i && half_cnt_q == HALF_MAX;
        half_cnt_d    = (!en_i || wrap) ? '0 : half_cnt_q + 1'b1;
        edge_cnt_d    = !en_i ? '0 : edge_cnt_q + 5'(wrap);
        lead_pulse_o  = wrap && !edge_cnt_q[0];
        trail_pulse_o = wrap && edge_cnt_q[0];
        last_edge_o   = wrap && edge_cnt_q == 5'(EDGES_PER_XFER - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
        end else begin
            half_cnt_q <= half_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end
endmodule

// File: rtl/spi_byte_master.sv
// spi_byte_master: byte-wide SPI master, one byte shifted out and in per accepted request
//   clk, rst      : clock, synchronous active-high reset
//   spitx/spitxdv : byte to send (MSB first) and request strobe, taken when spitxready=1
//   spitxready    : idle / able to accept (also high in the completion cycle)
//   spirx/spirxdv : last received byte and its one-cycle update pulse
//   spisclk/spimosi/spimiso : SPI pins (chip select is handled outside)
//   SPI_LOOPBACK_EN (macro) : adds spiloopback, sampling the registered spimosi instead of spimiso
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] spitx,
    input  logic       spitxdv,
    output logic       spitxready,
    output logic [7:0] spirx,
    output logic       spirxdv,
    output logic       spisclk,
    output logic       spimosi,
`ifdef SPI_LOOPBACK_EN
    input  logic       spiloopback,
`endif
    input  logic       spimiso
);
    localparam logic [1:0] MODE = 2'(SPI_MODE);
    localparam logic CPOL = MODE[CPOL_BIT];
    localparam logic CPHA = MODE[CPHA_BIT];

    if (SPI_MODE < 0 || SPI_MODE > 3) begin : g_bad_mode
        $error("SPI_MODE must be 0..3");
    end

    state_e state_q, state_d;
    logic [7:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, spirx_q, spirx_d;
    logic spirxdv_q, spirxdv_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic lead, trail, last_edge, accept, drive, sample, miso_bit;

    spi_sclk_gen #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_sclk_gen (
        .clk          (clk),
        .rst          (rst),
        .en_i         (state_q == SHIFT),
        .lead_pulse_o (lead),
        .trail_pulse_o(trail),
        .last_edge_o  (last_edge)
    );

`ifdef SPI_LOOPBACK_EN
    assign miso_bit = spiloopback ? mosi_q : spimiso;
`else
    assign miso_bit = spimiso;
`endif

    // CPHA=0 presents bit 7 at acceptance, so the final trailing edge has nothing left to drive.
    always_comb begin
        accept    = state_q != SHIFT && spitxdv;
        drive     = CPHA ? lead : trail && !last_edge;
        sample    = CPHA ? trail : lead;
        state_d   = state_q == SHIFT ? (last_edge ? DONE : SHIFT) : (accept ? SHIFT : IDLE);
        tx_sr_d   = accept ? spitx : drive ? {tx_sr_q[6:0], 1'b0} : tx_sr_q;
        mosi_d    = accept ? (CPHA ? mosi_q : spitx[7])
                  : drive ? (CPHA ? tx_sr_q[7] : tx_sr_q[6]) : mosi_q;
        rx_sr_d   = sample ? {rx_sr_q[6:0], miso_bit} : rx_sr_q;
        sclk_d    = sclk_q ^ (lead | trail);
        spirx_d   = state_q == DONE ? rx_sr_q : spirx_q;
        spirxdv_d = state_q == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            spirx_q   <= '0;
            spirxdv_q <= 1'b0;
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            spirx_q   <= spirx_d;
            spirxdv_q <= spirxdv_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign spitxready = state_q != SHIFT;
    assign spirx      = spirx_q;
    assign spirxdv    = spirxdv_q;
    assign spisclk    = sclk_q;
    assign spimosi    = mosi_q;
endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: all four SPI modes side by side against a transaction-level model and slave
module tb_spi_byte_master;
    localparam int H = 4;
`ifdef SPI_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] tx = 8'h00;
    logic txdv = 1'b0;
    bit lb = 1'b0;
    logic rdy [4];
    logic rxdv [4];
    logic sclk [4];
    logic mosi [4];
    logic miso [4];
    logic [7:0] rx [4];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_byte_master #(.SPI_MODE(m), .CLKS_PER_HALF_BIT(H)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .spitx      (tx),
            .spitxdv    (txdv),
            .spitxready (rdy[m]),
            .spirx      (rx[m]),
            .spirxdv    (rxdv[m]),
            .spisclk    (sclk[m]),
            .spimosi    (mosi[m]),
`ifdef SPI_LOOPBACK_EN
            .spiloopback(lb),
`endif
            .spimiso    (miso[m])
        );
    end

    int checks = 0;
    int errors = 0;

    int rem [4];
    int due [4];
    int ecnt [4];
    logic [7:0] pend [4], pend_tx [4], exp_rx [4], exp_mo [4], sb [4], s [4], cap [4], last_cap [4];
    logic exp_dv [4], acc [4], miso_r [4], psclk [4];
    logic [7:0] fixed_sb = 8'h00;
    bit fixed_en = 1'b1;

    for (genvar m = 0; m < 4; m++) begin : g_miso
        assign miso[m] = miso_r[m];
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s[mode %0d] got %0h expected %0h at %0t", name, k, act, expv, $time);
        end
    endtask

    function automatic logic cpol(input int k);
        return k[1];
    endfunction

    function automatic logic cpha(input int k);
        return k[0];
    endfunction

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            acc[k] = 1'b0;
            exp_dv[k] = 1'b0;
            if (rst) begin
                rem[k] = 0;
                due[k] = 0;
                exp_rx[k] = 8'h00;
            end else begin
                if (due[k] > 0) begin
                    due[k]--;
                    if (due[k] == 0) begin
                        exp_dv[k] = 1'b1;
                        exp_rx[k] = pend[k];
                        exp_mo[k] = pend_tx[k];
                    end
                end
                if (rem[k] > 0) rem[k]--;
                else if (txdv) begin
                    rem[k] = 16 * H;
                    due[k] = 16 * H + 1;
                    sb[k] = fixed_en ? fixed_sb : 8'($urandom);
                    pend[k] = (LB && lb) ? tx : sb[k];
                    pend_tx[k] = tx;
                    acc[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic cmp_step();
        for (int k = 0; k < 4; k++) begin
            chk("ready", k, rdy[k], rem[k] == 0);
            chk("rxdv", k, rxdv[k], exp_dv[k]);
            chk("rx", k, rx[k], exp_rx[k]);
            if (rem[k] == 0) chk("sclk_idle", k, sclk[k], cpol(k));
            if (exp_dv[k]) begin
                chk("mosi_byte", k, cap[k], exp_mo[k]);
                chk("sclk_edges", k, ecnt[k], 16);
                last_cap[k] = cap[k];
            end
            if (acc[k]) begin
                s[k] = sb[k];
                cap[k] = 8'h00;
                ecnt[k] = 0;
                if (!cpha(k)) begin
                    miso_r[k] = s[k][7];
                    s[k] = {s[k][6:0], 1'b0};
                end
            end else if (sclk[k] !== psclk[k]) begin
                ecnt[k]++;
                if ((sclk[k] != cpol(k)) == !cpha(k)) cap[k] = {cap[k][6:0], mosi[k]};
                else begin
                    miso_r[k] = s[k][7];
                    s[k] = {s[k][6:0], 1'b0};
                end
            end
            psclk[k] = sclk[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_step();
    endtask

    task automatic wait_dv(input int maxc, output int n);
        n = 0;
        while (rxdv[0] !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] slave);
        fixed_sb = slave;
        tx = b;
        txdv = 1'b1;
        tick();
        txdv = 1'b0;
    endtask

    int n, n2, cnt;

    initial begin
        for (int k = 0; k < 4; k++) begin
            rem[k] = 0; due[k] = 0; ecnt[k] = 0; exp_rx[k] = 8'h00; exp_dv[k] = 1'b0;
            acc[k] = 1'b0; miso_r[k] = 1'b0; psclk[k] = cpol(k); cap[k] = 8'h00; s[k] = 8'h00;
            last_cap[k] = 8'h00; sb[k] = 8'h00; pend[k] = 8'h00; pend_tx[k] = 8'h00; exp_mo[k] = 8'h00;
        end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rst_ready", k, rdy[k], 1);
            chk("rst_rxdv", k, rxdv[k], 0);
            chk("rst_rx", k, rx[k], 8'h00);
            chk("rst_sclk", k, sclk[k], k >= 2);
            chk("rst_mosi", k, mosi[k], 0);
        end

        send(8'hA5, 8'h3C);
        wait_dv(200, n);
        chk("t1_latency", 0, n, 65);
        chk("t1_rx", 0, rx[0], 8'h3C);
        chk("t1_mosi", 0, last_cap[0], 8'hA5);
        repeat (3) tick();

        chk("t2_idle_high", 3, sclk[3], 1);
        send(8'h81, 8'h7E);
        wait_dv(200, n);
        chk("t2_rx", 3, rx[3], 8'h7E);
        chk("t2_mosi", 3, last_cap[3], 8'h81);
        tick();
        chk("t2_sclk_end", 3, sclk[3], 1);

        fixed_sb = 8'h5A;
        tx = 8'h01;
        txdv = 1'b1;
        tick();
        tx = 8'h02;
        wait_dv(200, n);
        chk("t3_first", 0, n, 65);
        chk("t3_mosi1", 0, last_cap[0], 8'h01);
        txdv = 1'b0;
        tick();
        wait_dv(200, n2);
        chk("t3_gap", 0, n2 + 1, 65);
        chk("t3_mosi2", 0, last_cap[0], 8'h02);
        chk("t3_rx", 0, rx[0], 8'h5A);
        repeat (3) tick();

        send(8'h00, 8'h33);
        repeat (5 * H) tick();
        tx = 8'hFF;
        txdv = 1'b1;
        tick();
        txdv = 1'b0;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            cnt += int'(rxdv[0]);
        end
        chk("t4_pulses", 0, cnt, 1);
        chk("t4_mosi", 0, last_cap[0], 8'h00);
        chk("t4_rx", 0, rx[0], 8'h33);

        send(8'hF0, 8'h44);
        repeat (9 * H) tick();
        chk("t5_mid_sclk", 0, sclk[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ready", 0, rdy[0], 1);
        chk("t5_sclk", 0, sclk[0], 0);
        chk("t5_sclk", 3, sclk[3], 1);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            cnt += int'(rxdv[0]);
        end
        chk("t5_no_pulse", 0, cnt, 0);
        send(8'h55, 8'hAA);
        wait_dv(200, n);
        chk("t5_latency", 0, n, 65);
        chk("t5_rx", 0, rx[0], 8'hAA);
        chk("t5_mosi", 0, last_cap[0], 8'h55);
        repeat (3) tick();

`ifdef SPI_LOOPBACK_EN
        lb = 1'b1;
        send(8'hC3, 8'h00);
        wait_dv(200, n);
        chk("t6_loopback", 0, rx[0], 8'hC3);
        chk("t6_loopback", 3, rx[3], 8'hC3);
        repeat (3) tick();
        lb = 1'b0;
`else
        send(8'hC3, 8'h00);
        wait_dv(200, n);
        chk("t6_no_loopback", 0, rx[0], 8'h00);
        chk("t6_no_loopback", 3, rx[3], 8'h00);
        repeat (3) tick();
`endif

        fixed_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            lb = LB && (c % 2 == 1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            for (int i = 0; i < 700; i++) begin
                txdv = $urandom_range(3) == 0;
                tx = 8'($urandom);
                rst = $urandom_range(400) == 0;
                tick();
            end
            txdv = 1'b0;
            rst = 1'b0;
        end
        repeat (100) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
